// File: rtl/rgb_to_ycbcr_if.sv
// Pixel stream bundle for rgb_to_ycbcr.
//   in_*      : RGB input stream (valid/ready) with frame-start / line-end markers
//   out_*     : YCbCr output stream (valid/ready) with the same markers realigned
// modport slave  : the converter side
// modport master : the side that feeds RGB and sinks YCbCr
interface rgb_to_ycbcr_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       in_sof;
    logic       in_eol;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       out_sof;
    logic       out_eol;

    modport slave (
        input  in_valid, red, green, blue, in_sof, in_eol, out_ready,
        output in_ready, out_valid, y, cb, cr, out_sof, out_eol
    );

    modport master (
        output in_valid, red, green, blue, in_sof, in_eol, out_ready,
        input  in_ready, out_valid, y, cb, cr, out_sof, out_eol
    );
endinterface

// File: rtl/rgb_to_ycbcr.sv
// RGB -> YCbCr colour-space converter, 4-stage pipeline, 1 pixel/clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rgb_to_ycbcr_if.slave (RGB in, YCbCr out, valid/ready both sides)
// Parameter FULL_RANGE: 1 = full-range output 0..255, 0 = studio range.
// Stages: S1 input capture, S2 products, S3 biased sums, S4 saturated output.
// The whole pipeline advances as one unit whenever the output register is
// empty or being consumed, so in_ready is a pure function of out_valid/out_ready.

// One output channel: three constant multiplies, sum with rounding/offset, clamp.
module rgb_to_ycbcr_lane #(
    parameter logic signed [8:0] KR  = '0,
    parameter logic signed [8:0] KG  = '0,
    parameter logic signed [8:0] KB  = '0,
    parameter logic        [7:0] OFS = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] q
);
    // Rounding half-LSB plus the channel offset, both in 1/256 units.
    localparam logic signed [19:0] BIAS = 20'sd128 + $signed({4'd0, OFS, 8'd0});

    logic signed [8:0]  r_s, g_s, b_s;
    logic signed [17:0] p_r, p_g, p_b;
    logic signed [19:0] sum;

    // Channels are unsigned; a zero top bit keeps them positive as signed operands.
    assign r_s = $signed({1'b0, r});
    assign g_s = $signed({1'b0, g});
    assign b_s = $signed({1'b0, b});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r <= '0;
            p_g <= '0;
            p_b <= '0;
            sum <= '0;
            q   <= '0;
        end else if (en) begin
            p_r <= 18'(r_s) * 18'(KR);
            p_g <= 18'(g_s) * 18'(KG);
            p_b <= 18'(b_s) * 18'(KB);
            sum <= $signed({{2{p_r[17]}}, p_r}) + $signed({{2{p_g[17]}}, p_g})
                 + $signed({{2{p_b[17]}}, p_b}) + BIAS;
            // sum>>>8 is the result; negative -> 0, anything at or above 256 -> 255.
            if (sum[19])
                q <= 8'd0;
            else if (|sum[18:16])
                q <= 8'hff;
            else
                q <= sum[15:8];
        end
    end
endmodule

module rgb_to_ycbcr #(
    parameter bit FULL_RANGE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    rgb_to_ycbcr_if.slave  bus
);
    localparam int STAGES    = 4;
    localparam int NUM_LANES = 3;   // lane 0 = Y, 1 = Cb, 2 = Cr
    localparam int VEC_W     = 8;

    // Coefficients in 1/256 units, packed {Cr, Cb, Y}.
    localparam logic [NUM_LANES-1:0][8:0] KR = FULL_RANGE ?
        {9'(128),  9'(-43), 9'(77)}  : {9'(112), 9'(-38), 9'(66)};
    localparam logic [NUM_LANES-1:0][8:0] KG = FULL_RANGE ?
        {9'(-107), 9'(-85), 9'(150)} : {9'(-94), 9'(-74), 9'(129)};
    localparam logic [NUM_LANES-1:0][8:0] KB = FULL_RANGE ?
        {9'(-21),  9'(128), 9'(29)}  : {9'(-18), 9'(112), 9'(25)};
    localparam logic [NUM_LANES-1:0][7:0] OFS = FULL_RANGE ?
        {8'd128, 8'd128, 8'd0} : {8'd128, 8'd128, 8'd16};

    logic                             en;
    logic [STAGES:1]                  vld_pipe;
    logic [STAGES:1]                  sof_pipe;
    logic [STAGES:1]                  eol_pipe;
    logic [VEC_W-1:0]                 r1, g1, b1;
    logic [NUM_LANES-1:0][VEC_W-1:0]  pix_q;

    assign en           = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready = en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sof_pipe <= '0;
            eol_pipe <= '0;
            r1       <= '0;
            g1       <= '0;
            b1       <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
            // Markers only ride with real pixels so bubbles never carry them.
            sof_pipe <= {sof_pipe[STAGES-1:1], bus.in_valid & bus.in_sof};
            eol_pipe <= {eol_pipe[STAGES-1:1], bus.in_valid & bus.in_eol};
            r1       <= bus.red;
            g1       <= bus.green;
            b1       <= bus.blue;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        rgb_to_ycbcr_lane #(
            .KR (KR[i]),
            .KG (KG[i]),
            .KB (KB[i]),
            .OFS(OFS[i])
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .r    (r1),
            .g    (g1),
            .b    (b1),
            .q    (pix_q[i])
        );
    end

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_sof   = sof_pipe[STAGES];
    assign bus.out_eol   = eol_pipe[STAGES];
    assign bus.y         = pix_q[0];
    assign bus.cb        = pix_q[1];
    assign bus.cr        = pix_q[2];
endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// Bench for rgb_to_ycbcr: a full-range and a studio-range instance share one
// stimulus stream; a per-negedge monitor scores both against an arithmetic model.
module tb_rgb_to_ycbcr;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       s;
        logic       e;
    } px_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] red = '0, green = '0, blue = '0;
    logic       in_sof = 1'b0, in_eol = 1'b0;
    logic       out_ready = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int rd[2];
    int nout[2];
    bit stall_prev[2];
    logic [26:0] held[2];
    px_t in_q[$];

    always #5 clk = ~clk;

    rgb_to_ycbcr_if bf();
    rgb_to_ycbcr_if bs();

    assign bf.in_valid = in_valid;  assign bs.in_valid = in_valid;
    assign bf.red      = red;       assign bs.red      = red;
    assign bf.green    = green;     assign bs.green    = green;
    assign bf.blue     = blue;      assign bs.blue     = blue;
    assign bf.in_sof   = in_sof;    assign bs.in_sof   = in_sof;
    assign bf.in_eol   = in_eol;    assign bs.in_eol   = in_eol;
    assign bf.out_ready = out_ready; assign bs.out_ready = out_ready;

    rgb_to_ycbcr #(.FULL_RANGE(1'b1)) dut_full   (.clk(clk), .rst_n(rst_n), .bus(bf));
    rgb_to_ycbcr #(.FULL_RANGE(1'b0)) dut_studio (.clk(clk), .rst_n(rst_n), .bus(bs));

    logic [1:0]       ov, ir, osof, oeol;
    logic [1:0][23:0] opix;
    assign ov   = {bs.out_valid, bf.out_valid};
    assign ir   = {bs.in_ready, bf.in_ready};
    assign osof = {bs.out_sof, bf.out_sof};
    assign oeol = {bs.out_eol, bf.out_eol};
    assign opix[0] = {bf.y, bf.cb, bf.cr};
    assign opix[1] = {bs.y, bs.cb, bs.cr};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference conversion: {Y, Cb, Cr} straight from the coefficient tables.
    function automatic logic [23:0] model(input logic [7:0] r, g, b, input bit full);
        int k[3][3];
        int ofs[3];
        int v;
        int ri, gi, bi;
        logic [23:0] res;
        ri = int'(r); gi = int'(g); bi = int'(b);
        if (full) begin
            k   = '{'{77, 150, 29}, '{-43, -85, 128}, '{128, -107, -21}};
            ofs = '{0, 128, 128};
        end else begin
            k   = '{'{66, 129, 25}, '{-38, -74, 112}, '{112, -94, -18}};
            ofs = '{16, 128, 128};
        end
        res = '0;
        for (int c = 0; c < 3; c++) begin
            v = (k[c][0] * ri + k[c][1] * gi + k[c][2] * bi + 128 + ofs[c] * 256) >>> 8;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            res[23 - 8 * c -: 8] = v[7:0];
        end
        return res;
    endfunction

    // Monitor: everything is sampled on the negedge, i.e. what the next posedge will see.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
                chk($sformatf("rst_data[%0d]", i), 32'({opix[i], osof[i], oeol[i]}), 32'd0);
                chk($sformatf("rst_in_ready[%0d]", i), 32'(ir[i]), 32'd1);
                rd[i] = in_q.size();
                stall_prev[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(!(ov[i] && !out_ready)));
                if (stall_prev[i])
                    chk($sformatf("hold[%0d]", i), 32'({ov[i], opix[i], osof[i], oeol[i]}),
                        32'({1'b1, held[i][25:0]}));
                if (ov[i] && out_ready) begin
                    if (rd[i] >= in_q.size()) begin
                        chk($sformatf("spurious_out[%0d]", i), 32'(rd[i]), 32'(in_q.size() - 1));
                    end else begin
                        chk($sformatf("pix%0d[%0d]", rd[i], i),
                            32'({opix[i], osof[i], oeol[i]}),
                            32'({model(in_q[rd[i]].r, in_q[rd[i]].g, in_q[rd[i]].b, i == 0),
                                 in_q[rd[i]].s, in_q[rd[i]].e}));
                        rd[i]++;
                    end
                    nout[i]++;
                end
                stall_prev[i] = ov[i] && !out_ready;
                held[i] = {ov[i], opix[i], osof[i], oeol[i]};
            end
            if (in_valid && ir[0])
                in_q.push_back('{r: red, g: green, b: blue, s: in_sof, e: in_eol});
        end
    end

    // Present one pixel until accepted; call and return just after a posedge.
    task automatic send(input logic [7:0] r, g, b, input bit s, e);
        int t;
        bit got;
        t = 0;
        in_valid = 1'b1; red = r; green = g; blue = b; in_sof = s; in_eol = e;
        forever begin
            @(negedge clk);
            got = ir[0] && rst_n;
            @(posedge clk);
            #1;
            if (got) break;
            t++;
            if (t > 1000) begin
                chk("send_timeout", 32'(t), 32'd0);
                break;
            end
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    endtask

    // Pipeline empty, out_ready=1: the pixel just accepted must show after exactly 3 edges.
    task automatic lat_check(input logic [23:0] ef, input logic [23:0] es);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j < 3) begin
                chk($sformatf("lat_idle%0d", j), 32'(ov), 32'd0);
            end else begin
                chk("lat_valid", 32'(ov), 32'd3);
                chk("lat_full", 32'(opix[0]), 32'(ef));
                chk("lat_studio", 32'(opix[1]), 32'(es));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while ((rd[0] != in_q.size() || rd[1] != in_q.size() || ov != 2'b00) && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_full", 32'(rd[0]), 32'(in_q.size()));
        chk("drain_studio", 32'(rd[1]), 32'(in_q.size()));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        px_t burst[6];
        int base;
        bit done;
        rd = '{0, 0};
        nout = '{0, 0};
        stall_prev = '{1'b0, 1'b0};

        // Hand-computed values pinning the model.
        chk("model_black_f", 32'(model(8'd0, 8'd0, 8'd0, 1'b1)), 32'h008080);
        chk("model_white_f", 32'(model(8'd255, 8'd255, 8'd255, 1'b1)), 32'hFF8080);
        chk("model_red_f", 32'(model(8'd255, 8'd0, 8'd0, 1'b1)), 32'h4D55FF);
        chk("model_blue_f", 32'(model(8'd0, 8'd0, 8'd255, 1'b1)), 32'h1DFF6B);
        chk("model_black_s", 32'(model(8'd0, 8'd0, 8'd0, 1'b0)), 32'h108080);
        chk("model_white_s", 32'(model(8'd255, 8'd255, 8'd255, 1'b0)), 32'hEB8080);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed conversions with latency check.
        send(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);       lat_check(24'h008080, 24'h108080);
        send(8'd255, 8'd255, 8'd255, 1'b0, 1'b0); lat_check(24'hFF8080, 24'hEB8080);
        send(8'd255, 8'd0, 8'd0, 1'b0, 1'b0);     lat_check(24'h4D55FF, 24'h525AF0);
        send(8'd0, 8'd0, 8'd255, 1'b0, 1'b0);     lat_check(24'h1DFF6B, 24'h29F06E);
        drain();

        // Six back-to-back pixels, sink stalls for four cycles mid-burst.
        burst = '{'{8'd10, 8'd20, 8'd30, 1'b1, 1'b0}, '{8'd200, 8'd100, 8'd50, 1'b0, 1'b0},
                  '{8'd0, 8'd255, 8'd0, 1'b0, 1'b0},   '{8'd128, 8'd128, 8'd128, 1'b0, 1'b0},
                  '{8'd255, 8'd255, 8'd0, 1'b0, 1'b0}, '{8'd1, 8'd2, 8'd3, 1'b0, 1'b1}};
        base = nout[0];
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(burst[i].r, burst[i].g, burst[i].b, burst[i].s, burst[i].e);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("burst_count", 32'(nout[0] - base), 32'd6);

        // Reset pulse with three pixels in flight; a pixel offered during reset is ignored.
        send(8'd50, 8'd60, 8'd70, 1'b1, 1'b0);
        send(8'd80, 8'd90, 8'd100, 1'b0, 1'b0);
        send(8'd110, 8'd120, 8'd130, 1'b0, 1'b1);
        base = nout[0];
        rst_n = 1'b0;
        in_valid = 1'b1; red = 8'd33; green = 8'd44; blue = 8'd55;
        #1;
        chk("rst_immediate", 32'(ov), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        send(8'd255, 8'd0, 8'd0, 1'b0, 1'b0);
        lat_check(24'h4D55FF, 24'h525AF0);
        drain();
        chk("rst_discard", 32'(nout[0] - base), 32'd1);

        // Random stream with random gaps and back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(8'($urandom), 8'($urandom), 8'($urandom),
                         $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        drain();
        chk("count_match", 32'(nout[0]), 32'(nout[1]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
